// File: rtl/md_issue_ctrl_pkg.sv
// ============================================================================
// md_issue_ctrl_pkg
// Shared md op-class codes, ALUop encodings and issue-FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package md_issue_ctrl_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [5:0] ALU_NONE = 6'h00;
    localparam logic [5:0] ALU_MUL  = 6'h18;
    localparam logic [5:0] ALU_MULU = 6'h19;
    localparam logic [5:0] ALU_DIV  = 6'h1A;
    localparam logic [5:0] ALU_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } md_state_t;

    // Codes 9..15 fall outside this range and behave as NONE.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

    function automatic logic is_unit_op(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic [5:0] alu_of(input logic [3:0] op);
        case (op)
            OP_MULT:  return ALU_MUL;
            OP_MULTU: return ALU_MULU;
            OP_DIV:   return ALU_DIV;
            OP_DIVU:  return ALU_DIVU;
            default:  return ALU_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_issue_ctrl.sv
// ============================================================================
// md_issue_ctrl
// Issues mul/div/HI-LO ops from E, tracks unit occupancy and stalls D-stage md ops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_issue_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_md_op,
    input  logic [3:0]  e_md_op,
    input  logic        e_valid,
    input  logic        flush,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        busy_in,
    output logic        start,
    output logic [5:0]  ALUop,
    output logic        hilowe,
    output logic        hilo_A3,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    output logic        rd_en,
    output logic        rd_sel,
    output logic        stall,
    output logic        err_sync
);
    import md_issue_ctrl_pkg::*;

    localparam logic [3:0] C_MUL_CYC = MUL_CYC[3:0];
    localparam logic [3:0] C_DIV_CYC = DIV_CYC[3:0];

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic        r_err_sync;

    logic        w_busy;
    logic        w_issue_ok;
    logic        w_e_md;
    logic        w_e_unit;
    logic        w_e_is_mul;
    logic        w_d_md;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_issue_ok = e_valid & ~flush & ~reset;
    assign w_e_md     = is_md_op(e_md_op);
    assign w_e_unit   = is_unit_op(e_md_op);
    assign w_e_is_mul = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
    assign w_d_md     = is_md_op(d_md_op);

    // Nothing issues while the unit is occupied; such an op is a sync error.
    assign start   = w_issue_ok & w_e_unit & ~w_busy;
    assign ALUop   = start ? alu_of(e_md_op) : ALU_NONE;
    assign hilowe  = w_issue_ok & ~w_busy & ((e_md_op == OP_MTHI) || (e_md_op == OP_MTLO));
    assign hilo_A3 = hilowe & (e_md_op == OP_MTLO);
    assign rd_en   = w_issue_ok & ~w_busy & ((e_md_op == OP_MFHI) || (e_md_op == OP_MFLO));
    assign rd_sel  = rd_en & (e_md_op == OP_MFLO);
    assign stall   = ~reset & w_d_md & (w_busy | start);

    assign md_rs    = e_rs;
    assign md_rt    = e_rt;
    assign err_sync = r_err_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_err_sync <= 1'b0;
        end else begin
            if ((w_busy != busy_in) || (w_issue_ok & w_e_md & w_busy)) begin
                r_err_sync <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_e_is_mul) begin
                            r_state <= ST_MUL_WAIT;
                            r_cnt   <= C_MUL_CYC;
                        end else begin
                            r_state <= ST_DIV_WAIT;
                            r_cnt   <= C_DIV_CYC;
                        end
                    end
                end
                ST_MUL_WAIT, ST_DIV_WAIT: begin
                    // cnt counts remaining busy cycles including the current one.
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
// ============================================================================
// tb_md_issue_ctrl
// Directed vector table plus multi-cycle sequences for md_issue_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  d_md_op;
    logic [3:0]  e_md_op;
    logic        e_valid;
    logic        flush;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        busy_in;
    logic        start;
    logic [5:0]  ALUop;
    logic        hilowe;
    logic        hilo_A3;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        rd_en;
    logic        rd_sel;
    logic        stall;
    logic        err_sync;

    int n_cmp;
    int n_bad;

    md_issue_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_md_op(e_md_op),
        .e_valid(e_valid), .flush(flush), .e_rs(e_rs), .e_rt(e_rt),
        .busy_in(busy_in), .start(start), .ALUop(ALUop), .hilowe(hilowe),
        .hilo_A3(hilo_A3), .md_rs(md_rs), .md_rt(md_rt), .rd_en(rd_en),
        .rd_sel(rd_sel), .stall(stall), .err_sync(err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d_op;
        logic [3:0]  e_op;
        logic        ev;
        logic        fl;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        x_start;
        logic [5:0]  x_alu;
        logic        x_hilowe;
        logic        x_a3;
        logic        x_rd_en;
        logic        x_rd_sel;
        logic        x_stall;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic rst, input logic [3:0] d, input logic [3:0] e,
                       input logic ev, input logic fl, input logic bi);
        @(posedge clk);
        #1;
        reset   = rst;
        d_md_op = d;
        e_md_op = e;
        e_valid = ev;
        flush   = fl;
        busy_in = bi;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b1, OP_NONE, OP_NONE, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        d_md_op = OP_NONE;
        e_md_op = OP_NONE;
        e_valid = 1'b0;
        flush   = 1'b0;
        e_rs    = 32'd0;
        e_rt    = 32'd0;
        busy_in = 1'b0;

        //             d_op      e_op      ev fl rs            rt            st alu       hw a3 rd sel stall
        vecs[0]  = '{OP_NONE,  OP_MULT,  1, 0, 32'd3,        32'hFFFFFFFE, 1, ALU_MUL,  0, 0, 0, 0, 0};
        vecs[1]  = '{OP_MFLO,  OP_MULTU, 1, 0, 32'h11111111, 32'h22222222, 1, ALU_MULU, 0, 0, 0, 0, 1};
        vecs[2]  = '{OP_MULT,  OP_DIV,   1, 0, 32'h33333333, 32'h44444444, 1, ALU_DIV,  0, 0, 0, 0, 1};
        vecs[3]  = '{OP_NONE,  OP_DIVU,  1, 0, 32'd7,        32'd2,        1, ALU_DIVU, 0, 0, 0, 0, 0};
        vecs[4]  = '{OP_MFHI,  OP_MULT,  1, 1, 32'h55555555, 32'h66666666, 0, ALU_NONE, 0, 0, 0, 0, 0};
        vecs[5]  = '{OP_MFHI,  OP_MULT,  0, 0, 32'h77777777, 32'h88888888, 0, ALU_NONE, 0, 0, 0, 0, 0};
        vecs[6]  = '{OP_NONE,  OP_MTHI,  1, 0, 32'h00001234, 32'h0,        0, ALU_NONE, 1, 0, 0, 0, 0};
        vecs[7]  = '{OP_NONE,  OP_MTLO,  1, 0, 32'h00005678, 32'h0,        0, ALU_NONE, 1, 1, 0, 0, 0};
        vecs[8]  = '{OP_NONE,  OP_MFHI,  1, 0, 32'h9,        32'hA,        0, ALU_NONE, 0, 0, 1, 0, 0};
        vecs[9]  = '{OP_NONE,  OP_MFLO,  1, 0, 32'hB,        32'hC,        0, ALU_NONE, 0, 0, 1, 1, 0};
        vecs[10] = '{OP_MTHI,  4'd9,     1, 0, 32'hD,        32'hE,        0, ALU_NONE, 0, 0, 0, 0, 0};
        vecs[11] = '{4'd15,    4'd15,    1, 0, 32'hF,        32'h10,       0, ALU_NONE, 0, 0, 0, 0, 0};
        vecs[12] = '{OP_MFLO,  OP_MTLO,  1, 1, 32'h12,       32'h13,       0, ALU_NONE, 0, 0, 0, 0, 0};

        // Reset overrides active inputs.
        e_rs = 32'd1; e_rt = 32'd2;
        cyc(1'b1, OP_MFLO, OP_MULT, 1'b1, 1'b0, 1'b0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hilowe", {31'd0, hilowe}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        cyc(1'b0, OP_MFLO, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("rst_idle_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, err_sync}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            e_rs = vecs[i].rs;
            e_rt = vecs[i].rt;
            cyc(1'b0, vecs[i].d_op, vecs[i].e_op, vecs[i].ev, vecs[i].fl, 1'b0);
            chk($sformatf("v%0d_start", i), {31'd0, start}, {31'd0, vecs[i].x_start});
            chk($sformatf("v%0d_alu", i), {26'd0, ALUop}, {26'd0, vecs[i].x_alu});
            chk($sformatf("v%0d_hilowe", i), {31'd0, hilowe}, {31'd0, vecs[i].x_hilowe});
            chk($sformatf("v%0d_a3", i), {31'd0, hilo_A3}, {31'd0, vecs[i].x_a3});
            chk($sformatf("v%0d_rd_en", i), {31'd0, rd_en}, {31'd0, vecs[i].x_rd_en});
            chk($sformatf("v%0d_rd_sel", i), {31'd0, rd_sel}, {31'd0, vecs[i].x_rd_sel});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].x_stall});
            chk($sformatf("v%0d_md_rs", i), md_rs, vecs[i].rs);
            chk($sformatf("v%0d_md_rt", i), md_rt, vecs[i].rt);
        end

        // mult 3 * -2, mflo waiting in D.
        do_reset();
        e_rs = 32'd3; e_rt = 32'hFFFFFFFE;
        cyc(1'b0, OP_MFLO, OP_MULT, 1'b1, 1'b0, 1'b0);
        chk("mul_start", {31'd0, start}, 32'd1);
        chk("mul_alu", {26'd0, ALUop}, {26'd0, ALU_MUL});
        chk("mul_stall0", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            cyc(1'b0, OP_MFLO, OP_NONE, 1'b0, 1'b0, 1'b1);
            chk($sformatf("mul_stall%0d", c), {31'd0, stall}, 32'd1);
        end
        cyc(1'b0, OP_MFLO, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("mul_stall6", {31'd0, stall}, 32'd0);
        cyc(1'b0, OP_NONE, OP_MFLO, 1'b1, 1'b0, 1'b0);
        chk("mul_rd_en", {31'd0, rd_en}, 32'd1);
        chk("mul_rd_sel", {31'd0, rd_sel}, 32'd1);
        chk("mul_err", {31'd0, err_sync}, 32'd0);

        // divu 7/2, mfhi in D; a non-md D op mid-way must not stall.
        do_reset();
        e_rs = 32'd7; e_rt = 32'd2;
        cyc(1'b0, OP_MFHI, OP_DIVU, 1'b1, 1'b0, 1'b0);
        chk("divu_start", {31'd0, start}, 32'd1);
        chk("divu_alu", {26'd0, ALUop}, {26'd0, ALU_DIVU});
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0, (c == 5) ? OP_NONE : OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b1);
            chk($sformatf("divu_stall%0d", c), {31'd0, stall}, (c == 5) ? 32'd0 : 32'd1);
        end
        cyc(1'b0, OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("divu_stall11", {31'd0, stall}, 32'd0);
        cyc(1'b0, OP_NONE, OP_MFHI, 1'b1, 1'b0, 1'b0);
        chk("divu_rd_en", {31'd0, rd_en}, 32'd1);
        chk("divu_rd_sel", {31'd0, rd_sel}, 32'd0);
        chk("divu_err", {31'd0, err_sync}, 32'd0);

        // div, then a flushed md op in E: no second start, schedule unchanged.
        do_reset();
        cyc(1'b0, OP_MFHI, OP_DIV, 1'b1, 1'b0, 1'b0);
        chk("fl_start0", {31'd0, start}, 32'd1);
        cyc(1'b0, OP_MFHI, OP_MULT, 1'b1, 1'b1, 1'b1);
        chk("fl_start1", {31'd0, start}, 32'd0);
        for (int c = 2; c <= 10; c++) begin
            cyc(1'b0, OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b1);
        end
        chk("fl_stall10", {31'd0, stall}, 32'd1);
        cyc(1'b0, OP_MFHI, OP_MULT, 1'b1, 1'b0, 1'b0);
        chk("fl_start11", {31'd0, start}, 32'd1);
        chk("fl_err", {31'd0, err_sync}, 32'd0);

        // Reset in cycle 3 of a div.
        do_reset();
        cyc(1'b0, OP_MFHI, OP_DIV, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, OP_MFHI, OP_MULT, 1'b1, 1'b0, 1'b1);
        chk("rd_mid_stall", {31'd0, stall}, 32'd0);
        chk("rd_mid_start", {31'd0, start}, 32'd0);
        cyc(1'b0, OP_MFHI, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("rd_after_stall", {31'd0, stall}, 32'd0);
        chk("rd_after_err", {31'd0, err_sync}, 32'd0);

        // busy_in drops during MUL_WAIT: sticky error until reset.
        do_reset();
        cyc(1'b0, OP_NONE, OP_MULT, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OP_NONE, OP_NONE, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, OP_NONE, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("bz_err_pre", {31'd0, err_sync}, 32'd0);
        cyc(1'b0, OP_NONE, OP_NONE, 1'b0, 1'b0, 1'b1);
        chk("bz_err_set", {31'd0, err_sync}, 32'd1);
        for (int c = 4; c <= 8; c++) begin
            cyc(1'b0, OP_NONE, OP_NONE, 1'b0, 1'b0, (c <= 5) ? 1'b1 : 1'b0);
        end
        chk("bz_err_hold", {31'd0, err_sync}, 32'd1);
        do_reset();
        cyc(1'b0, OP_NONE, OP_NONE, 1'b0, 1'b0, 1'b0);
        chk("bz_err_clr", {31'd0, err_sync}, 32'd0);

        // Valid md op reaching E while busy: suppressed and flagged.
        do_reset();
        cyc(1'b0, OP_NONE, OP_MULT, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OP_NONE, OP_MFHI, 1'b1, 1'b0, 1'b1);
        chk("eb_rd_en", {31'd0, rd_en}, 32'd0);
        chk("eb_err_pre", {31'd0, err_sync}, 32'd0);
        cyc(1'b0, OP_NONE, OP_MTHI, 1'b1, 1'b0, 1'b1);
        chk("eb_hilowe", {31'd0, hilowe}, 32'd0);
        chk("eb_err", {31'd0, err_sync}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
